// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg
// Shared constants for the register hazard scoreboard: register index width,
// default maximum result latency and the latency class of each instruction
// kind. Latencies are counted in bubble cycles before a result can be
// forwarded.
package hazard_scoreboard_pkg;

  localparam int REG_IDX_W   = 5;
  localparam int DEF_MAX_LAT = 3;

  localparam int LAT_ALU  = 0;
  localparam int LAT_LOAD = 1;
  localparam int LAT_CSR  = 1;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if
// Bundles the decode-side issue request, the source operand lookups, the
// backend controls and the scoreboard responses.
//   master : decode stage (drives issue/source/hold/flush, reads responses)
//   slave  : scoreboard   (reads the request, drives hazard/issue_fire/
//            busy/stall_cycles)
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int LAT_W    = $clog2(DEF_MAX_LAT + 1)
);
  logic                issue_valid;
  reg_idx_t            issue_rd;
  logic                issue_reg_we;
  logic [LAT_W-1:0]    issue_lat;
  reg_idx_t            rs1;
  logic                rs1_used;
  reg_idx_t            rs2;
  logic                rs2_used;
  logic                hold;
  logic                flush;
  logic                hazard;
  logic                issue_fire;
  logic [NUM_REGS-1:0] busy;
  logic [31:0]         stall_cycles;

  modport master (
    output issue_valid, issue_rd, issue_reg_we, issue_lat,
    output rs1, rs1_used, rs2, rs2_used, hold, flush,
    input  hazard, issue_fire, busy, stall_cycles
  );

  modport slave (
    input  issue_valid, issue_rd, issue_reg_we, issue_lat,
    input  rs1, rs1_used, rs2, rs2_used, hold, flush,
    output hazard, issue_fire, busy, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard_entry.sv
// scoreboard_entry
// Pending-result counter for one architectural register.
//   clk, rst : clock, asynchronous active-high reset
//   i_hold   : freeze the counter (flush clear still applies)
//   i_load   : load i_lat (already saturated by the caller)
//   i_lat    : latency to load
//   i_clr    : squash the pending result (killed instruction)
//   o_busy   : counter is nonzero
module scoreboard_entry
  import hazard_scoreboard_pkg::*;
#(
  parameter int LAT_W = $clog2(DEF_MAX_LAT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_hold,
  input  logic             i_load,
  input  logic [LAT_W-1:0] i_lat,
  input  logic             i_clr,
  output logic             o_busy
);

  logic [LAT_W-1:0] r_cnt;

  // Clear wins over hold; a new load wins over the decrement (newest write).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (!i_hold) begin
      if (i_load)
        r_cnt <= i_lat;
      else if (r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// In-order issue scoreboard: tracks outstanding register writes by latency
// and bubbles decode while a used source register is still pending.
//   clk, rst : clock, asynchronous active-high reset
//   sb       : slave side of hazard_scoreboard_if
//              issue_valid/rd/reg_we/lat : instruction in decode
//              rs1/rs2 (+_used)          : its source operands
//              hold                      : backend stall, freezes state
//              flush                     : kill decode and last issued instr
//              hazard, issue_fire        : decode control
//              busy                      : per-register pending bits
//              stall_cycles              : free-running hazard cycle count
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int MAX_LAT  = DEF_MAX_LAT,
  parameter int LAT_W    = $clog2(MAX_LAT + 1)
) (
  input logic               clk,
  input logic               rst,
  hazard_scoreboard_if.slave sb
);

  logic [NUM_REGS-1:0] w_busy;
  logic                w_hazard;
  logic                w_fire;
  logic                w_load_en;
  logic                w_last_valid;
  logic [LAT_W-1:0]    w_lat_sat;

  logic                r_last_valid;
  reg_idx_t            r_last_rd;
  logic [31:0]         r_stall_cycles;

  function automatic logic [LAT_W-1:0] sat_lat(input logic [LAT_W-1:0] lat);
    logic [LAT_W-1:0] cap;
    cap = LAT_W'(MAX_LAT);
    return (lat > cap) ? cap : lat;
  endfunction

  // x0 is hardwired and never pending.
  assign w_busy[0] = 1'b0;

  genvar g;
  generate
    for (g = 1; g < NUM_REGS; g++) begin : g_entry
      scoreboard_entry #(.LAT_W(LAT_W)) u_entry (
        .clk    (clk),
        .rst    (rst),
        .i_hold (sb.hold),
        .i_load (w_load_en && (sb.issue_rd == REG_IDX_W'(g))),
        .i_lat  (w_lat_sat),
        .i_clr  (sb.flush && r_last_valid && (r_last_rd == REG_IDX_W'(g))),
        .o_busy (w_busy[g])
      );
    end
  endgenerate

  // Looks only at pre-edge state, so an instruction never stalls on its own rd.
  assign w_hazard = sb.issue_valid &&
                    ((sb.rs1_used && (sb.rs1 != '0) && w_busy[sb.rs1]) ||
                     (sb.rs2_used && (sb.rs2 != '0) && w_busy[sb.rs2]));

  assign w_fire       = sb.issue_valid && !w_hazard && !sb.hold && !sb.flush;
  assign w_load_en    = w_fire && sb.issue_reg_we && (sb.issue_rd != '0);
  assign w_lat_sat    = sat_lat(sb.issue_lat);
  // Zero-latency results are forwardable at once, so there is nothing to kill.
  assign w_last_valid = w_load_en && (sb.issue_lat != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_valid   <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      if (sb.flush)
        r_last_valid <= 1'b0;
      else if (!sb.hold)
        r_last_valid <= w_last_valid;
      if (w_hazard && !sb.hold)
        r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  // Destination index is only meaningful alongside r_last_valid.
  always_ff @(posedge clk) begin
    if (!sb.hold)
      r_last_rd <= sb.issue_rd;
  end

  assign sb.hazard       = w_hazard;
  assign sb.issue_fire   = w_fire;
  assign sb.busy         = w_busy;
  assign sb.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
// Directed bench for hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  int   c;

  hazard_scoreboard_if #(.NUM_REGS(32), .LAT_W(2)) sb ();

  hazard_scoreboard #(.NUM_REGS(32), .MAX_LAT(3)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sb.issue_valid  = 1'b0;
    sb.issue_rd     = '0;
    sb.issue_reg_we = 1'b0;
    sb.issue_lat    = '0;
    sb.rs1          = '0;
    sb.rs1_used     = 1'b0;
    sb.rs2          = '0;
    sb.rs2_used     = 1'b0;
    sb.hold         = 1'b0;
    sb.flush        = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [1:0] lat);
    idle();
    sb.issue_valid  = 1'b1;
    sb.issue_rd     = rd;
    sb.issue_reg_we = 1'b1;
    sb.issue_lat    = lat;
  endtask

  task automatic consumer(input logic [4:0] r1, input logic u1,
                          input logic [4:0] r2, input logic u2);
    idle();
    sb.issue_valid = 1'b1;
    sb.issue_rd    = 5'd11;
    sb.rs1         = r1;
    sb.rs1_used    = u1;
    sb.rs2         = r2;
    sb.rs2_used    = u2;
  endtask

  // Counts cycles with hazard=1, holding the backend in cycles hf..ht.
  task automatic count_hazard(input int hf, input int ht, output int cnt);
    cnt = 0;
    for (int n = 0; n < 12; n++) begin
      sb.hold = (n >= hf && n <= ht);
      #1;
      if (!sb.hazard) begin
        sb.hold = 1'b0;
        break;
      end
      cnt++;
      tick();
    end
    sb.hold = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    idle();
    rst = 1'b1;
    consumer(5'd5, 1'b1, 5'd0, 1'b0);
    #12;
    chk("rst_busy",   sb.busy, 32'h0);
    chk("rst_hazard", 32'(sb.hazard), 32'd0);
    chk("rst_fire",   32'(sb.issue_fire), 32'd1);
    chk("rst_stall",  sb.stall_cycles, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    tick();

    // Load-use
    issue(5'd5, 2'(LAT_LOAD));
    #1;
    chk("lu_issue_fire", 32'(sb.issue_fire), 32'd1);
    tick();
    consumer(5'd5, 1'b1, 5'd0, 1'b0);
    #1;
    chk("lu_hazard1", 32'(sb.hazard), 32'd1);
    chk("lu_fire1",   32'(sb.issue_fire), 32'd0);
    chk("lu_busy5",   32'(sb.busy[5]), 32'd1);
    tick();
    #1;
    chk("lu_hazard2", 32'(sb.hazard), 32'd0);
    chk("lu_fire2",   32'(sb.issue_fire), 32'd1);
    chk("lu_stall",   sb.stall_cycles, 32'd1);
    tick();
    idle();

    // Long latency, no hold
    issue(5'd7, 2'd3);
    tick();
    consumer(5'd0, 1'b0, 5'd7, 1'b1);
    count_hazard(99, 98, c);
    chk("ll_cycles", 32'(c), 32'd3);
    chk("ll_busy7",  32'(sb.busy[7]), 32'd0);
    chk("ll_stall",  sb.stall_cycles, 32'd4);
    tick();
    idle();

    // Long latency with two hold cycles in the middle
    issue(5'd7, 2'd3);
    tick();
    consumer(5'd0, 1'b0, 5'd7, 1'b1);
    count_hazard(1, 2, c);
    chk("llh_cycles", 32'(c), 32'd5);
    chk("llh_stall",  sb.stall_cycles, 32'd7);
    tick();
    idle();

    // WAW override
    issue(5'd4, 2'd1);
    tick();
    issue(5'd4, 2'd3);
    #1;
    chk("waw_fire", 32'(sb.issue_fire), 32'd1);
    tick();
    consumer(5'd4, 1'b1, 5'd0, 1'b0);
    count_hazard(99, 98, c);
    chk("waw_cycles", 32'(c), 32'd3);
    chk("waw_stall",  sb.stall_cycles, 32'd10);
    tick();
    idle();

    // x0 and unused sources
    issue(5'd0, 2'd3);
    tick();
    idle();
    #1;
    chk("x0_busy", sb.busy, 32'h0);
    issue(5'd9, 2'd3);
    tick();
    consumer(5'd9, 1'b0, 5'd0, 1'b1);
    #1;
    chk("unused_busy9",  32'(sb.busy[9]), 32'd1);
    chk("unused_hazard", 32'(sb.hazard), 32'd0);
    tick();
    sb.rs1_used = 1'b1;
    #1;
    chk("used_hazard", 32'(sb.hazard), 32'd1);
    idle();
    tick();
    tick();
    chk("drain_busy", sb.busy, 32'h0);

    // Flush with hold: kill rd=6, rd=13 stays frozen
    issue(5'd13, 2'd3);
    tick();
    issue(5'd6, 2'd2);
    tick();
    issue(5'd12, 2'd1);
    sb.flush = 1'b1;
    sb.hold  = 1'b1;
    #1;
    chk("fl_fire",  32'(sb.issue_fire), 32'd0);
    chk("fl_busy6", 32'(sb.busy[6]), 32'd1);
    tick();
    idle();
    #1;
    chk("fl_busy6_clr", 32'(sb.busy[6]), 32'd0);
    chk("fl_busy12",    32'(sb.busy[12]), 32'd0);
    chk("fl_busy13_a",  32'(sb.busy[13]), 32'd1);
    tick();
    chk("fl_busy13_b",  32'(sb.busy[13]), 32'd1);
    tick();
    chk("fl_busy13_c",  32'(sb.busy[13]), 32'd0);
    chk("fl_stall",     sb.stall_cycles, 32'd10);

    // Asynchronous reset mid-operation
    issue(5'd3, 2'd3);
    tick();
    issue(5'd8, 2'd3);
    tick();
    consumer(5'd3, 1'b1, 5'd0, 1'b0);
    #1;
    chk("ar_hazard_pre", 32'(sb.hazard), 32'd1);
    chk("ar_busy_pre",   {30'd0, sb.busy[8], sb.busy[3]}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_busy",   sb.busy, 32'h0);
    chk("ar_hazard", 32'(sb.hazard), 32'd0);
    chk("ar_stall",  sb.stall_cycles, 32'd0);
    chk("ar_fire",   32'(sb.issue_fire), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("ar_post_busy",  sb.busy, 32'h0);
    chk("ar_post_stall", sb.stall_cycles, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
